// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared types and defaults for the multiport register file.
// Revision : 1.0
// ============================================================================
package rf_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : rf_clear_seq
// Brief    : Clear sweep sequencer: zeroes one entry per cycle, drives busy.
// Revision : 1.0
// ============================================================================
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_req,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] c_LAST = {ADDR_W{1'b1}};

    rf_state_t         r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_CLEAR;
            r_idx   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                RF_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= RF_CLEAR;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    // clr_req is ignored here: a running sweep is never extended
                    if (r_idx == c_LAST) begin
                        r_state <= RF_IDLE;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= RF_CLEAR;
                    r_idx   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_clr_we   = (r_state == RF_CLEAR);
    assign o_clr_addr = r_idx;

endmodule
`default_nettype wire

// File: rtl/rf_multiport.sv
`default_nettype none
// ============================================================================
// Module   : rf_multiport
// Brief    : Parametrised register file, NUM_RD async read ports, one write
//            port, hardware clear sweep. Optional macro RF_BYPASS_EN enables
//            same-cycle write-to-read forwarding.
// Revision : 1.0
// ============================================================================
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     busy,
    output logic                     wr_rej
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_rej;
    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_zero;
    logic              w_wr_acc;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .i_clr_req  (clr_req),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Zero-register writes vanish silently; they are not reported as rejects.
    assign w_wr_zero = (ZERO_REG != 0) && (waddr == '0);
    assign w_wr_acc  = we && !w_busy && !clr_req && !rst && !w_wr_zero;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_rej <= 1'b0;
        end else begin
            r_wr_rej <= we && (w_busy || clr_req);
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rd;

            assign w_ra = raddr[k*ADDR_W +: ADDR_W];

            always_comb begin
                w_rd = r_mem[w_ra];
                if (w_busy || ((ZERO_REG != 0) && (w_ra == '0))) begin
                    w_rd = '0;
`ifdef RF_BYPASS_EN
                end else if (we && (w_ra == waddr) && !w_wr_zero) begin
                    w_rd = wdata;
`endif
                end
            end

            assign rdata[k*DATA_W +: DATA_W] = w_rd;
        end
    endgenerate

    assign busy   = w_busy;
    assign wr_rej = r_wr_rej;

endmodule
`default_nettype wire

// File: tb/tb_rf_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_multiport
// Brief    : Self-checking bench for rf_multiport against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_rf_multiport;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_req;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic             busy;
    logic             wr_rej;

    always #5 clk = ~clk;

    rf_multiport #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr),
        .rdata   (rdata),
        .busy    (busy),
        .wr_rej  (wr_rej)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left;
    logic          m_rej;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int a);
        if (m_left > 0) return '0;
`ifdef RF_BYPASS_EN
        if (we && (int'(waddr) == a) && (a != 0)) return wdata;
`endif
        if (a == 0) return '0;
        return m_mem[a];
    endfunction

    task automatic m_zero();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance the model.
    task automatic step(input logic r, input logic c, input logic w, input int wa,
                        input logic [DW-1:0] wd, input int ra0, input int ra1);
        rst     = r;
        clr_req = c;
        we      = w;
        waddr   = AW'(wa);
        wdata   = wd;
        raddr   = {AW'(ra1), AW'(ra0)};
        @(negedge clk);
        chk("busy",   DW'(busy),   DW'(m_left > 0));
        chk("wr_rej", DW'(wr_rej), DW'(m_rej));
        chk("rd0",    rdata[0 +: DW],  m_read(ra0));
        chk("rd1",    rdata[DW +: DW], m_read(ra1));
        @(posedge clk);
        if (r) begin
            m_left = DEPTH;
            m_rej  = 1'b0;
            m_zero();
        end else if (m_left > 0) begin
            m_rej = w;
            m_left--;
        end else if (c) begin
            m_rej  = w;
            m_left = DEPTH;
            m_zero();
        end else begin
            m_rej = 1'b0;
            if (w && wa != 0) m_mem[wa] = wd;
        end
        #1;
    endtask

    task automatic idle(input int ra0, input int ra1);
        step(1'b0, 1'b0, 1'b0, 0, '0, ra0, ra1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        rst = 1'b1; clr_req = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        repeat (3) @(posedge clk);
        #1;
        m_left = DEPTH; m_rej = 1'b0; m_zero();
        chk("rst_busy",   DW'(busy),   DW'(1));
        chk("rst_wr_rej", DW'(wr_rej), DW'(0));
        chk("rst_rdata",  rdata[0 +: DW], '0);

        // Release reset and measure the sweep
        cnt = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            idle(i % DEPTH, (i + 7) % DEPTH);
            cnt++;
        end
        chk("sweep_len", DW'(cnt), DW'(32));
        for (int a = 0; a < DEPTH; a++) idle(a, DEPTH - 1 - a);

        // Basic write/read
        step(1'b0, 1'b0, 1'b1, 5,  32'hDEADBEEF, 5, 31);
        step(1'b0, 1'b0, 1'b1, 31, 32'h12345678, 5, 31);
        idle(5, 31);
        chk("r5_val",  rdata[0 +: DW],  32'hDEADBEEF);
        chk("r31_val", rdata[DW +: DW], 32'h12345678);

        // Zero register
        step(1'b0, 1'b0, 1'b1, 0, 32'hFFFFFFFF, 0, 0);
        idle(0, 5);
        chk("r0_val",  rdata[0 +: DW], '0);
        chk("r0_rej",  DW'(wr_rej), DW'(0));

        // Runtime clear colliding with a write
        step(1'b0, 1'b0, 1'b1, 7, 32'hA5A5A5A5, 7, 9);
        step(1'b0, 1'b1, 1'b1, 9, 32'h1, 7, 9);
        chk("clr_rej", DW'(wr_rej), DW'(1));
        cnt = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            idle(7, 9);
            cnt++;
        end
        chk("clr_len", DW'(cnt), DW'(32));
        idle(7, 9);
        chk("r7_clr", rdata[0 +: DW],  '0);
        chk("r9_clr", rdata[DW +: DW], '0);

        // Reset in the middle of a sweep, with a write attempted while busy
        step(1'b0, 1'b0, 1'b1, 12, 32'h0BADF00D, 12, 1);
        step(1'b0, 1'b1, 1'b0, 0, '0, 12, 1);
        for (int i = 0; i < 10; i++) idle(12, 1);
        step(1'b1, 1'b0, 1'b0, 0, '0, 12, 1);
        cnt = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            if (i == 3) step(1'b0, 1'b0, 1'b1, 12, 32'hCAFEF00D, 12, 1);
            else        idle(12, 1);
            cnt++;
        end
        chk("mid_rst_len", DW'(cnt), DW'(32));
        idle(12, 1);
        chk("r12_dropped", rdata[0 +: DW], '0);

        // Same-cycle write and read of one address
        step(1'b0, 1'b0, 1'b1, 3, 32'h55, 3, 3);
        idle(3, 4);
        chk("r3_after", rdata[0 +: DW], 32'h55);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            logic r, c, w;
            int   wa, ra0, ra1;
            r   = ($urandom_range(0, 199) == 0);
            c   = ($urandom_range(0, 79) == 0);
            w   = $urandom_range(0, 1) == 1;
            wa  = $urandom_range(0, DEPTH - 1);
            ra0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
            ra1 = $urandom_range(0, DEPTH - 1);
            step(r, c, w, wa, $urandom, ra0, ra1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
